controle_entrada_saida: RTL and testbench
=========================================

// Module: controle_entrada_saida
// PURPOSE
// - Sequences the processor's I/O instructions against the board I/O: IN blocks the CPU until the
//   operator confirms switch data with the button; OUT latches a word for the BCD display.
// - Sits between control unit / datapath (io_ctrl, write data, stall) and board pins (switches,
//   button, display word).
// - Replaces free-running capture with a debounced, stall-based handshake.
// PARAMETERS
// - DEBOUNCE_CYCLES    50000  consecutive stable cycles required to accept a button level change (>=2)
// - BOTAO_ATIVO_BAIXO  1      1: botao_in is pressed when 0; 0: pressed when 1
// - LIMITE_DISPLAY     999    largest value the 3-digit BCD display can show
// PORTS
// - clk            in   1   system clock, all state on posedge
// - reset_n        in   1   asynchronous, active-low reset
// - io_ctrl        in   2   2'b01 = OUT, 2'b10 = IN, 2'b00/2'b11 = no-op; CPU holds it stable while stall=1
// - dados_escrita  in   32  word to display on OUT
// - botao_in       in   1   raw confirm button (asynchronous)
// - entrada_dados  in   4   raw switches (asynchronous)
// - dados_lidos    out  32  last captured input, zero-extended {28'b0, sw}
// - dado_display   out  32  last OUT word, held
// - display_valid  out  1   sticky; 1 after the first OUT since reset
// - display_overflow out 1  dado_display > LIMITE_DISPLAY
// - stall          out  1   freezes PC/pipeline while an IN is pending
// - aguardando     out  1   LED: waiting for the operator (WAIT_PRESS state)
// BEHAVIOUR
// - Reset (async, reset_n=0): state IDLE; all outputs 0; sync/debounce regs at released level;
//   debounce counter 0. Reset mid-IN aborts the IN; stall drops immediately.
// - Sync: botao_in and entrada_dados each pass a 2-flop synchronizer before use.
//   Polarity is normalised by BOTAO_ATIVO_BAIXO into internal btn (1 = pressed).
// - Debounce: counter counts cycles with btn != btn_db and clears when they are equal.
//   At count DEBOUNCE_CYCLES-1: btn_db <= btn, counter <= 0. Pulses shorter than DEBOUNCE_CYCLES are ignored.
// - FSM states IDLE, WAIT_PRESS, WAIT_RELEASE, DONE:
//   - IDLE: io_ctrl==10 -> WAIT_PRESS. io_ctrl==01 -> stay IDLE; next edge dado_display <= dados_escrita,
//     display_valid <= 1. Otherwise stay IDLE.
//   - WAIT_PRESS: aguardando=1. On btn_db rising: dados_lidos <= {28'b0, sw_sync} captured that edge
//     -> WAIT_RELEASE. If btn_db is already 1 on entry, first wait for release, then a new press.
//   - WAIT_RELEASE: btn_db falling -> DONE. Holding the button keeps the CPU stalled.
//   - DONE: one cycle, stall=0 so the CPU retires the IN -> IDLE. An io_ctrl==10 seen in IDLE
//     afterwards is a new IN.
// - stall (combinational) = (state==IDLE && io_ctrl==2'b10) | state==WAIT_PRESS | state==WAIT_RELEASE.
//   The CPU never advances past an IN on the cycle it is decoded.
// - OUT latency: 1 clock, with no stall. Back-to-back OUTs: each updates dado_display; last one wins.
// - io_ctrl==11 is treated as a no-op with no state change.
// - OUT while stalled cannot occur (CPU frozen) and is ignored outside IDLE.
// - dados_lidos and dado_display hold their values until overwritten or reset.
// - display_overflow is a combinational compare of the full 32-bit unsigned dado_display.
// STRUCTURE
// - Shared package/header (io_pkg): IO_NOP=2'b00, IO_OUT=2'b01, IO_IN=2'b10 and the FSM state encodings.
//   The decoder and the existing BCD display driver use the same io_ctrl constants.
// - One sub-module: debounce_botao (2-flop sync + counter + btn_db and rise/fall pulse outputs),
//   parameterised by DEBOUNCE_CYCLES.
// - Switch sync, FSM and output registers live in the top.
// TESTING (DEBOUNCE_CYCLES=4, BOTAO_ATIVO_BAIXO=0)
// - Reset: reset_n=0 mid-WAIT_RELEASE -> stall=0, dados_lidos=0, dado_display=0, display_valid=0 at once.
// - OUT: io_ctrl=01, dados_escrita=123 for 1 cycle -> dado_display=123 next edge, display_valid=1,
//   stall never 1, overflow=0. Then write 1000 -> overflow=1.
// - IN: io_ctrl=10, sw=4'hA, button high 10 cycles then low -> stall=1 from the decode cycle.
//   dados_lidos=32'h0000000A once the debounced press is accepted (2 sync + 4 debounce cycles).
//   stall drops for exactly 1 cycle in DONE after the debounced release.
// - Bounce: during WAIT_PRESS, 3-cycle high glitches x5 -> no capture, stays WAIT_PRESS, aguardando=1.
// - Held button: button already pressed when IN issues -> no capture until release + new press.
//   sw changed between the two presses -> the second value is captured.
// - Back-to-back: OUT 7 then IN (sw=5) then OUT 42 -> display 7 during the IN wait, dados_lidos=5,
//   display 42 one cycle after the final OUT.

Source files
------------

// File: rtl/io_pkg.sv
// Shared I/O instruction codes and controller state encodings.
// The decoder and the BCD display driver use the same io_ctrl constants.
package io_pkg;

  localparam logic [1:0] IO_NOP = 2'b00;
  localparam logic [1:0] IO_OUT = 2'b01;
  localparam logic [1:0] IO_IN  = 2'b10;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    WAIT_PRESS   = 2'b01,
    WAIT_RELEASE = 2'b10,
    DONE         = 2'b11
  } estado_t;

endpackage

// File: rtl/debounce_botao.sv
// Confirm-button conditioning: 2-flop synchronizer, polarity normalisation,
// stable-level debounce and one-cycle rise/fall pulses aligned with btn_db.
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ATIVO_BAIXO     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic botao_in,
  output logic btn_db,
  output logic rise,
  output logic fall
);

  localparam int       CW    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic     SOLTO = ATIVO_BAIXO ? 1'b1 : 1'b0;
  localparam [CW-1:0]  ULTIMO = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic          btn;
  logic [CW-1:0] cnt;

  assign btn = ATIVO_BAIXO ? ~sync_b : sync_b;

  // Synchronizer, debounce counter and edge pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= SOLTO;
      sync_b <= SOLTO;
      cnt    <= '0;
      btn_db <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_a <= botao_in;
      sync_b <= sync_a;
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (btn != btn_db) begin
        // A level must differ on DEBOUNCE_CYCLES consecutive edges to be accepted.
        if (cnt == ULTIMO) begin
          btn_db <= btn;
          cnt    <= '0;
          rise   <= btn;
          fall   <= ~btn;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/controle_entrada_saida.sv
// I/O instruction sequencer: OUT latches a display word, IN stalls the CPU
// until the operator confirms the switches with a debounced press/release.
module controle_entrada_saida #(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter bit BOTAO_ATIVO_BAIXO = 1'b1,
  parameter int LIMITE_DISPLAY    = 999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  io_ctrl,
  input  logic [31:0] dados_escrita,
  input  logic        botao_in,
  input  logic [3:0]  entrada_dados,
  output logic [31:0] dados_lidos,
  output logic [31:0] dado_display,
  output logic        display_valid,
  output logic        display_overflow,
  output logic        stall,
  output logic        aguardando
);

  import io_pkg::*;

  estado_t    estado;
  logic [3:0] sw_a;
  logic [3:0] sw_sync;
  logic       btn_db;
  logic       btn_rise;
  logic       btn_fall;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ATIVO_BAIXO    (BOTAO_ATIVO_BAIXO)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .botao_in(botao_in),
    .btn_db  (btn_db),
    .rise    (btn_rise),
    .fall    (btn_fall)
  );

  // Switch synchronizer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_a    <= 4'd0;
      sw_sync <= 4'd0;
    end else begin
      sw_a    <= entrada_dados;
      sw_sync <= sw_a;
    end
  end

  // Controller FSM with its output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado        <= IDLE;
      dados_lidos   <= 32'd0;
      dado_display  <= 32'd0;
      display_valid <= 1'b0;
    end else begin
      case (estado)
        IDLE: begin
          if (io_ctrl == IO_IN) begin
            estado <= WAIT_PRESS;
          end else if (io_ctrl == IO_OUT) begin
            dado_display  <= dados_escrita;
            display_valid <= 1'b1;
          end else begin
            estado <= IDLE;
          end
        end
        WAIT_PRESS: begin
          // Only a fresh press counts; a button already held on entry yields no rise.
          if (btn_rise) begin
            dados_lidos <= {28'd0, sw_sync};
            estado      <= WAIT_RELEASE;
          end else begin
            estado <= WAIT_PRESS;
          end
        end
        WAIT_RELEASE: begin
          if (btn_fall) begin
            estado <= DONE;
          end else begin
            estado <= WAIT_RELEASE;
          end
        end
        DONE:    estado <= IDLE;
        default: estado <= IDLE;
      endcase
    end
  end

  // Stall covers the decode cycle of an IN; reset releases the pipeline at once.
  always_comb begin
    stall      = 1'b0;
    aguardando = 1'b0;
    if (reset_n) begin
      stall = ((estado == IDLE) && (io_ctrl == IO_IN)) ||
              (estado == WAIT_PRESS) || (estado == WAIT_RELEASE);
      aguardando = (estado == WAIT_PRESS);
    end else begin
      stall      = 1'b0;
      aguardando = 1'b0;
    end
  end

  assign display_overflow = (dado_display > 32'(LIMITE_DISPLAY));

endmodule

// File: tb/tb_controle_entrada_saida.sv
// Directed bench for controle_entrada_saida with a short debounce window
// and an active-high button.
module tb_controle_entrada_saida;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  io_ctrl;
  logic [31:0] dados_escrita;
  logic        botao_in;
  logic [3:0]  entrada_dados;
  logic [31:0] dados_lidos;
  logic [31:0] dado_display;
  logic        display_valid;
  logic        display_overflow;
  logic        stall;
  logic        aguardando;

  int errors = 0;
  int checks = 0;

  controle_entrada_saida #(
    .DEBOUNCE_CYCLES  (4),
    .BOTAO_ATIVO_BAIXO(1'b0),
    .LIMITE_DISPLAY   (999)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .io_ctrl         (io_ctrl),
    .dados_escrita   (dados_escrita),
    .botao_in        (botao_in),
    .entrada_dados   (entrada_dados),
    .dados_lidos     (dados_lidos),
    .dado_display    (dado_display),
    .display_valid   (display_valid),
    .display_overflow(display_overflow),
    .stall           (stall),
    .aguardando      (aguardando)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the number of cycles until stall drops, or -1 when the bound expires.
  task automatic wait_stall_drop(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 60; i++) begin
      step(1);
      if (stall === 1'b0) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; io_ctrl = 2'b00; dados_escrita = 32'd0;
    botao_in = 1'b0; entrada_dados = 4'h0;
    #1;
    checks++;
    if ({dados_lidos, dado_display, display_valid, display_overflow, stall, aguardando} !== 68'd0) begin
      errors++; $display("FAIL reset_outputs got lidos=%h disp=%h v=%b ov=%b st=%b ag=%b want all 0",
                         dados_lidos, dado_display, display_valid, display_overflow, stall, aguardando);
    end
    step(2);
    reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_out;
    io_ctrl = 2'b01; dados_escrita = 32'd123;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL out_no_stall got %b want 0", stall); end
    step(1);
    io_ctrl = 2'b00;
    #1;
    checks++;
    if (dado_display !== 32'd123 || display_valid !== 1'b1 || display_overflow !== 1'b0) begin
      errors++; $display("FAIL out_123 got disp=%0d v=%b ov=%b want 123 1 0", dado_display, display_valid, display_overflow);
    end
    io_ctrl = 2'b01; dados_escrita = 32'd999;
    step(1);
    io_ctrl = 2'b00;
    checks++;
    if (dado_display !== 32'd999 || display_overflow !== 1'b0) begin
      errors++; $display("FAIL out_999 got disp=%0d ov=%b want 999 0", dado_display, display_overflow);
    end
    io_ctrl = 2'b01; dados_escrita = 32'd1000;
    step(1);
    io_ctrl = 2'b11;
    checks++;
    if (dado_display !== 32'd1000 || display_overflow !== 1'b1) begin
      errors++; $display("FAIL out_1000 got disp=%0d ov=%b want 1000 1", dado_display, display_overflow);
    end
    step(2);
    checks++;
    if (stall !== 1'b0 || aguardando !== 1'b0 || dado_display !== 32'd1000) begin
      errors++; $display("FAIL nop_11 got st=%b ag=%b disp=%0d want 0 0 1000", stall, aguardando, dado_display);
    end
    io_ctrl = 2'b00;
  endtask

  task automatic test_in;
    io_ctrl = 2'b10; entrada_dados = 4'hA; botao_in = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL in_decode_stall got %b want 1", stall); end
    step(6);
    checks++;
    if (dados_lidos !== 32'd0 || aguardando !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL in_before_capture got lidos=%h ag=%b st=%b want 0 1 1", dados_lidos, aguardando, stall);
    end
    step(1);
    checks++;
    if (dados_lidos !== 32'h0000000A || aguardando !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL in_capture got lidos=%h ag=%b st=%b want 0000000a 0 1", dados_lidos, aguardando, stall);
    end
    step(3);
    botao_in = 1'b0;
    step(6);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL in_hold_until_release got %b want 1", stall); end
    step(1);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL in_done_stall got %b want 0", stall); end
    io_ctrl = 2'b00;
    step(1);
    checks++;
    if (stall !== 1'b0 || dados_lidos !== 32'h0000000A) begin
      errors++; $display("FAIL in_retired got st=%b lidos=%h want 0 0000000a", stall, dados_lidos);
    end
  endtask

  task automatic test_bounce;
    int c;
    io_ctrl = 2'b10; entrada_dados = 4'h6;
    for (int k = 0; k < 5; k++) begin
      botao_in = 1'b1; step(3);
      botao_in = 1'b0; step(3);
    end
    step(6);
    checks++;
    if (aguardando !== 1'b1 || stall !== 1'b1 || dados_lidos !== 32'h0000000A) begin
      errors++; $display("FAIL bounce_ignored got ag=%b st=%b lidos=%h want 1 1 0000000a", aguardando, stall, dados_lidos);
    end
    entrada_dados = 4'h9; botao_in = 1'b1;
    step(10);
    botao_in = 1'b0;
    wait_stall_drop(c);
    checks++;
    if (c < 0 || dados_lidos !== 32'h00000009) begin
      errors++; $display("FAIL bounce_real_press got cycles=%0d lidos=%h want drop and 00000009", c, dados_lidos);
    end
    io_ctrl = 2'b00;
    step(1);
  endtask

  task automatic test_held;
    int c;
    botao_in = 1'b1;
    step(10);
    io_ctrl = 2'b10; entrada_dados = 4'h3;
    step(12);
    checks++;
    if (aguardando !== 1'b1 || dados_lidos !== 32'h00000009) begin
      errors++; $display("FAIL held_no_capture got ag=%b lidos=%h want 1 00000009", aguardando, dados_lidos);
    end
    botao_in = 1'b0;
    step(10);
    checks++;
    if (aguardando !== 1'b1 || stall !== 1'b1 || dados_lidos !== 32'h00000009) begin
      errors++; $display("FAIL held_release_only got ag=%b st=%b lidos=%h want 1 1 00000009", aguardando, stall, dados_lidos);
    end
    entrada_dados = 4'hC; botao_in = 1'b1;
    step(10);
    botao_in = 1'b0;
    wait_stall_drop(c);
    checks++;
    if (c < 0 || dados_lidos !== 32'h0000000C) begin
      errors++; $display("FAIL held_second_press got cycles=%0d lidos=%h want drop and 0000000c", c, dados_lidos);
    end
    io_ctrl = 2'b00;
    step(1);
  endtask

  task automatic test_back_to_back;
    int c;
    io_ctrl = 2'b01; dados_escrita = 32'd7;
    step(1);
    io_ctrl = 2'b10; entrada_dados = 4'h5; dados_escrita = 32'd0;
    botao_in = 1'b1;
    step(10);
    checks++;
    if (dado_display !== 32'd7 || stall !== 1'b1 || display_overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_display_during_in got disp=%0d st=%b ov=%b want 7 1 0", dado_display, stall, display_overflow);
    end
    botao_in = 1'b0;
    wait_stall_drop(c);
    checks++;
    if (c < 0 || dados_lidos !== 32'h00000005) begin
      errors++; $display("FAIL b2b_in got cycles=%0d lidos=%h want drop and 00000005", c, dados_lidos);
    end
    io_ctrl = 2'b00;
    step(1);
    io_ctrl = 2'b01; dados_escrita = 32'd42;
    step(1);
    io_ctrl = 2'b00;
    checks++;
    if (dado_display !== 32'd42 || display_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_out42 got disp=%0d v=%b want 42 1", dado_display, display_valid);
    end
  endtask

  task automatic test_reset_mid_in;
    io_ctrl = 2'b10; entrada_dados = 4'h2; botao_in = 1'b1;
    step(8);
    checks++;
    if (stall !== 1'b1 || aguardando !== 1'b0 || dados_lidos !== 32'h00000002) begin
      errors++; $display("FAIL rst_setup got st=%b ag=%b lidos=%h want 1 0 00000002", stall, aguardando, dados_lidos);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || dados_lidos !== 32'd0 || dado_display !== 32'd0 ||
        display_valid !== 1'b0 || aguardando !== 1'b0) begin
      errors++; $display("FAIL rst_mid_in got st=%b lidos=%h disp=%h v=%b ag=%b want all 0",
                         stall, dados_lidos, dado_display, display_valid, aguardando);
    end
    io_ctrl = 2'b00; botao_in = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(3);
    checks++;
    if (stall !== 1'b0 || aguardando !== 1'b0 || display_valid !== 1'b0) begin
      errors++; $display("FAIL rst_after got st=%b ag=%b v=%b want 0 0 0", stall, aguardando, display_valid);
    end
  endtask

  initial begin
    test_reset();
    test_out();
    test_in();
    test_bounce();
    test_held();
    test_back_to_back();
    test_reset_mid_in();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
